// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: shared types and constants for the DSP48A1 dot-product sequencer.
package dsp_seq_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;
   localparam int A_W = 18;
   localparam int P_W = 48;
   localparam logic [7:0] OPM_FIRST = 8'h01;
   localparam logic [7:0] OPM_ACC = 8'h09;
   localparam int OPM_PREADD_BIT = 4;
endpackage

// File: rtl/dsp_seq_dly.sv
// dsp_seq_dly: fixed-depth shift register delaying the slot opmode to meet the slice MREG output.
module dsp_seq_dly #(
   parameter int DEPTH = 1,
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [DEPTH-1:0][W-1:0] sr_q;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) sr_q <= '0;
      else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
   assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives one DSP48A1 slice as an N-term signed dot-product engine.
// Optional pre-adder operand (D+B)*A enabled by macro DSP_SEQ_PREADD_EN.
module dsp_mac_sequencer
   import dsp_seq_pkg::*;
#(
   parameter int LEN_W = 8,
   parameter int PIPE_LAT = 3,
   parameter int OPM_DLY = PIPE_LAT - 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [A_W-1:0]   op_a,
   input  logic [A_W-1:0]   op_b,
`ifdef DSP_SEQ_PREADD_EN
   input  logic [A_W-1:0]   op_d,
`endif
   output logic             res_valid,
   input  logic             res_ready,
   output logic [P_W-1:0]   res_data,
   output logic [A_W-1:0]   dsp_a,
   output logic [A_W-1:0]   dsp_b,
   output logic [A_W-1:0]   dsp_d,
   output logic [P_W-1:0]   dsp_c,
   output logic             dsp_carryin,
   output logic [7:0]       dsp_opmode,
   output logic             dsp_ce,
   output logic             dsp_cep,
   output logic             dsp_rst,
   input  logic [P_W-1:0]   dsp_p
);
   localparam int DC_W = $clog2(PIPE_LAT + 1);
`ifdef DSP_SEQ_PREADD_EN
   localparam logic [7:0] OPM_PRE = 8'(1 << OPM_PREADD_BIT);
`else
   localparam logic [7:0] OPM_PRE = 8'h00;
`endif
   state_e state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [DC_W-1:0] dcnt_q, dcnt_d;
   logic first_q, first_d;
   logic [P_W-1:0] res_q, res_d;
   logic rst_q;
   logic xfer;
   logic [7:0] opm_slot;
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state_q <= IDLE;
         cnt_q <= '0;
         dcnt_q <= '0;
         first_q <= 1'b0;
         res_q <= '0;
         rst_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         dcnt_q <= dcnt_d;
         first_q <= first_d;
         res_q <= res_d;
         rst_q <= 1'b0;
      end
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      dcnt_d = dcnt_q;
      first_d = first_q;
      res_d = res_q;
      opm_slot = '0;
      case (state_q)
         IDLE: if (start) begin
            state_d = (len == '0) ? DONE : LOAD;
            cnt_d = len;
            first_d = 1'b1;
            res_d = '0;
         end
         LOAD: begin
            // Only the first slot clears P; every later slot, bubble or not, accumulates.
            opm_slot = (first_q ? OPM_FIRST : OPM_ACC) | OPM_PRE;
            first_d = 1'b0;
            if (xfer) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == LEN_W'(1)) begin
                  state_d = DRAIN;
                  dcnt_d = DC_W'(PIPE_LAT - 1);
               end
            end
         end
         DRAIN: begin
            opm_slot = OPM_ACC | OPM_PRE;
            dcnt_d = dcnt_q - 1'b1;
            if (dcnt_q == '0) begin
               state_d = DONE;
               res_d = dsp_p;
            end
         end
         DONE: if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   dsp_seq_dly #(.DEPTH(OPM_DLY), .W(8)) u_dly (
      .clk_i(CLK),
      .rst_i(RST),
      .d_i(opm_slot),
      .q_o(dsp_opmode)
   );
   assign busy = state_q != IDLE;
   assign op_ready = state_q == LOAD;
   assign xfer = op_ready & op_valid;
   assign dsp_a = xfer ? op_a : '0;
   assign dsp_b = xfer ? op_b : '0;
`ifdef DSP_SEQ_PREADD_EN
   assign dsp_d = xfer ? op_d : '0;
`else
   assign dsp_d = '0;
`endif
   assign dsp_c = '0;
   assign dsp_carryin = 1'b0;
   assign dsp_ce = (state_q == LOAD) | (state_q == DRAIN);
   assign dsp_cep = dsp_ce;
   assign dsp_rst = rst_q;
   assign res_valid = state_q == DONE;
   assign res_data = res_q;
endmodule
